// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the data producers, the arbiter and the uart transmit path.
// Requester handshake: req[i] is valid and req_data/req_last must stay stable; the byte of
// requester i is consumed on a rising edge where req[i] && ack[i], and only then may it advance.
interface uart_tx_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic                    tx_full;
    logic                    wr_uart;
    logic [DATA_W-1:0]       w_data;
    logic [N_REQ-1:0]        ack;
    logic [N_REQ-1:0]        grant;
    logic                    busy;

    modport master (
        output req, req_data, req_last, tx_full,
        input  wr_uart, w_data, ack, grant, busy
    );

    modport slave (
        input  req, req_data, req_last, tx_full,
        output wr_uart, w_data, ack, grant, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart TX FIFO between N_REQ byte producers.
// A grant is held until the owner's last byte or MAX_BURST written bytes.
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus,
    output logic             dbg_state
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] owner, owner_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_nxt;
    logic [CNT_W-1:0] burst_cnt, cnt_nxt;
    logic [IDX_W-1:0] pick;
    logic             found;
    logic [N_REQ-1:0] owner_oh;

    assign dbg_state = state;

    // First requesting index at or above rr_ptr, wrapping around.
    always_comb begin
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        rr_nxt      = rr_ptr;
        cnt_nxt     = burst_cnt;
        bus.wr_uart = 1'b0;
        bus.w_data  = '0;
        bus.ack     = '0;
        bus.grant   = '0;
        bus.busy    = 1'b0;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_nxt = S_GRANT;
                    owner_nxt = pick;
                    cnt_nxt   = '0;
                end
            end
            S_GRANT: begin
                bus.grant   = owner_oh;
                bus.busy    = 1'b1;
                // tx_full gates the strobe in the same cycle, so a full FIFO never sees a write.
                bus.wr_uart = bus.req[owner] & ~bus.tx_full;
                if (bus.wr_uart) begin
                    bus.w_data = bus.req_data[owner*DATA_W +: DATA_W];
                    bus.ack    = owner_oh;
                    cnt_nxt    = burst_cnt + 1'b1;
                    if (bus.req_last[owner] || burst_cnt == CNT_W'(MAX_BURST - 1)) begin
                        state_nxt = S_IDLE;
                        rr_nxt    = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte sources per requester, an ordered expected-write
// queue, and cycle-exact checks of grant/write timing.
module tb_uart_tx_arbiter;
    localparam int N_REQ     = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;
    localparam int W         = 2 + DATA_W;

    logic clk = 1'b0;
    logic reset;
    logic dbg_state;

    uart_tx_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

    uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    logic [DATA_W-1:0] src_data [N_REQ][16];
    logic              src_last [N_REQ][16];
    int                src_len  [N_REQ];
    int                src_pos  [N_REQ];
    bit                hold     [N_REQ];
    logic              tf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < N_REQ; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
            hold[i]    = 1'b0;
        end
    endtask

    task automatic load(input int r, input int n, input logic [7:0] base, input bit with_last);
        for (int k = 0; k < n; k++) begin
            src_data[r][src_len[r]] = base + 8'(k);
            src_last[r][src_len[r]] = with_last && (k == n - 1);
            src_len[r]++;
        end
    endtask

    task automatic exp_push(input int r, input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) exp_q.push_back({r[1:0], base + 8'(k)});
    endtask

    task automatic drive();
        logic [N_REQ-1:0]        r;
        logic [N_REQ-1:0]        l;
        logic [N_REQ*DATA_W-1:0] d;
        r = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (src_pos[i] < src_len[i]) begin
                r[i]                = !hold[i];
                d[i*DATA_W +: DATA_W] = src_data[i][src_pos[i]];
                l[i]                = src_last[i][src_pos[i]];
            end
        end
        bus.req      = r;
        bus.req_data = d;
        bus.req_last = l;
        bus.tx_full  = tf;
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < N_REQ; i++) if (src_pos[i] < src_len[i]) p = 1'b1;
        return p;
    endfunction

    // Called at the mid-cycle sample point: scores the current cycle, then moves to the next one.
    task automatic cycle();
        logic [N_REQ-1:0] acked;
        logic [W-1:0]     got;
        int               oi;
        acked = bus.ack;
        if (bus.wr_uart === 1'b1) begin
            oi = 0;
            for (int i = 0; i < N_REQ; i++) if (bus.grant[i]) oi = i;
            got = {oi[1:0], bus.w_data};
            chk("grant_onehot_on_write", 32'($onehot(bus.grant)), 1);
            chk("ack_is_owner", 32'(bus.ack), 32'(bus.grant));
            chk("write_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("write_owner_data", 32'(got), 32'(exp_q.pop_front()));
        end else begin
            chk("no_ack_without_write", 32'(bus.ack), 0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) if (acked[i] && src_pos[i] < src_len[i]) src_pos[i]++;
        drive();
        #4;
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int n = 0;
        while ((pending() || bus.busy === 1'b1) && n < max_cycles) begin
            cycle();
            n++;
        end
        chk({tag, "_drain"}, 32'(n < max_cycles), 1);
        chk({tag, "_exp_empty"}, 32'(exp_q.size()), 0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive();
        #4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        tf    = 1'b0;
        clear_src();
        drive();
        #2;
        chk("rst_wr_uart", 32'(bus.wr_uart), 0);
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_w_data", 32'(bus.w_data), 0);
        chk("rst_state", 32'(dbg_state), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive();
        #4;

        // Single requester, 3-byte message.
        load(1, 3, 8'h41, 1'b1);
        exp_push(1, 3, 8'h41);
        cycle();
        chk("t1_c0_grant", 32'(bus.grant), 0);
        chk("t1_c0_wr", 32'(bus.wr_uart), 0);
        cycle();
        chk("t1_c1_grant", 32'(bus.grant), 32'h2);
        chk("t1_c1_wr", 32'(bus.wr_uart), 1);
        chk("t1_c1_data", 32'(bus.w_data), 32'h41);
        chk("t1_c1_ack", 32'(bus.ack), 32'h2);
        chk("t1_c1_busy", 32'(bus.busy), 1);
        chk("t1_c1_state", 32'(dbg_state), 1);
        cycle();
        chk("t1_c2_data", 32'(bus.w_data), 32'h42);
        cycle();
        chk("t1_c3_data", 32'(bus.w_data), 32'h43);
        chk("t1_c3_ack", 32'(bus.ack), 32'h2);
        cycle();
        chk("t1_c4_grant", 32'(bus.grant), 0);
        chk("t1_c4_busy", 32'(bus.busy), 0);
        chk("t1_c4_wr", 32'(bus.wr_uart), 0);
        chk("t1_exp_empty", 32'(exp_q.size()), 0);

        // Round robin after reset: 0 then 2; next round (pointer at 3): 3 then 0.
        apply_reset();
        clear_src();
        load(0, 2, 8'hA0, 1'b1);
        load(2, 2, 8'hC0, 1'b1);
        exp_push(0, 2, 8'hA0);
        exp_push(2, 2, 8'hC0);
        cycle();
        cycle();
        chk("t2_c1_grant", 32'(bus.grant), 32'h1);
        cycle();
        cycle();
        chk("t2_c3_dead_grant", 32'(bus.grant), 0);
        chk("t2_c3_dead_busy", 32'(bus.busy), 0);
        cycle();
        chk("t2_c4_grant", 32'(bus.grant), 32'h4);
        chk("t2_c4_data", 32'(bus.w_data), 32'hC0);
        drain("t2a", 20);
        clear_src();
        load(0, 2, 8'hB0, 1'b1);
        load(3, 2, 8'hD0, 1'b1);
        exp_push(3, 2, 8'hD0);
        exp_push(0, 2, 8'hB0);
        cycle();
        cycle();
        chk("t2b_c1_grant", 32'(bus.grant), 32'h8);
        drain("t2b", 20);

        // tx_full stall of 5 cycles after the first byte.
        clear_src();
        load(1, 3, 8'h31, 1'b1);
        exp_push(1, 3, 8'h31);
        cycle();
        cycle();
        chk("t3_c1_data", 32'(bus.w_data), 32'h31);
        tf = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t3_stall_wr", 32'(bus.wr_uart), 0);
            chk("t3_stall_ack", 32'(bus.ack), 0);
            chk("t3_stall_grant", 32'(bus.grant), 32'h2);
        end
        tf = 1'b0;
        cycle();
        chk("t3_c7_wr", 32'(bus.wr_uart), 1);
        chk("t3_c7_data", 32'(bus.w_data), 32'h32);
        cycle();
        chk("t3_c8_data", 32'(bus.w_data), 32'h33);
        cycle();
        chk("t3_c9_grant", 32'(bus.grant), 0);
        chk("t3_exp_empty", 32'(exp_q.size()), 0);

        // Forced release at MAX_BURST=4; the sixth byte closes the message on the second grant.
        clear_src();
        load(0, 6, 8'h01, 1'b1);
        load(1, 2, 8'h11, 1'b1);
        exp_push(0, 4, 8'h01);
        exp_push(1, 2, 8'h11);
        exp_push(0, 2, 8'h05);
        cycle();
        cycle();
        chk("t4_c1_grant", 32'(bus.grant), 32'h1);
        cycle();
        cycle();
        cycle();
        chk("t4_c4_data", 32'(bus.w_data), 32'h04);
        chk("t4_c4_grant", 32'(bus.grant), 32'h1);
        cycle();
        chk("t4_c5_grant", 32'(bus.grant), 0);
        chk("t4_c5_wr", 32'(bus.wr_uart), 0);
        cycle();
        chk("t4_c6_grant", 32'(bus.grant), 32'h2);
        cycle();
        cycle();
        chk("t4_c8_grant", 32'(bus.grant), 0);
        cycle();
        chk("t4_c9_grant", 32'(bus.grant), 32'h1);
        chk("t4_c9_data", 32'(bus.w_data), 32'h05);
        drain("t4", 20);

        // Reset between edges mid-message, then 0 beats 3 from a cleared pointer.
        clear_src();
        load(3, 4, 8'h51, 1'b1);
        exp_push(3, 1, 8'h51);
        cycle();
        cycle();
        chk("t5_c1_grant", 32'(bus.grant), 32'h8);
        chk("t5_c1_data", 32'(bus.w_data), 32'h51);
        cycle();
        chk("t5_c2_wr", 32'(bus.wr_uart), 1);
        reset = 1'b0;
        #1;
        chk("t5_rst_wr", 32'(bus.wr_uart), 0);
        chk("t5_rst_ack", 32'(bus.ack), 0);
        chk("t5_rst_grant", 32'(bus.grant), 0);
        chk("t5_rst_busy", 32'(bus.busy), 0);
        clear_src();
        load(0, 2, 8'h61, 1'b1);
        load(3, 1, 8'h71, 1'b1);
        exp_push(0, 2, 8'h61);
        exp_push(3, 1, 8'h71);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive();
        #4;
        chk("t5_c0_grant", 32'(bus.grant), 0);
        cycle();
        chk("t5_c1b_grant", 32'(bus.grant), 32'h1);
        drain("t5", 20);

        // Owner pauses for 3 cycles; the pending requester 2 waits for the owner's last byte.
        clear_src();
        load(0, 4, 8'h81, 1'b1);
        load(2, 1, 8'h91, 1'b1);
        exp_push(0, 4, 8'h81);
        exp_push(2, 1, 8'h91);
        cycle();
        cycle();
        chk("t6_c1_grant", 32'(bus.grant), 32'h1);
        cycle();
        hold[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t6_hold_wr", 32'(bus.wr_uart), 0);
            chk("t6_hold_grant", 32'(bus.grant), 32'h1);
        end
        hold[0] = 1'b0;
        cycle();
        chk("t6_c6_data", 32'(bus.w_data), 32'h83);
        cycle();
        chk("t6_c7_data", 32'(bus.w_data), 32'h84);
        cycle();
        chk("t6_c8_grant", 32'(bus.grant), 0);
        cycle();
        chk("t6_c9_grant", 32'(bus.grant), 32'h4);
        chk("t6_c9_data", 32'(bus.w_data), 32'h91);
        drain("t6", 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
